// File: rtl/axis_to_pull_pkg.sv
// ============================================================================
// Module : axis_to_pull_pkg
// Brief  : Shared state encoding, level arithmetic and width helpers for the
//          axis_to_pull stream-to-pull converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axis_to_pull_pkg;

    typedef enum logic [0:0] {
        PRIMING = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer addressing 0..depth-1; never collapses below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [31:0] next_level(
        input logic [31:0] level,
        input logic        pull,
        input logic        push
    );
        return level - 32'(pull) + 32'(push);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_to_pull_ram.sv
// ============================================================================
// Module : axis_to_pull_ram
// Brief  : DEPTH x WIDTH register-array FIFO storage with wrapping write/read
//          pointers and a registered read port. Storage itself is not reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_to_pull_ram
    import axis_to_pull_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int                   PTR_WIDTH = ptr_width(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_d;
    logic [WIDTH-1:0]     rd_data_q;
    logic [WIDTH-1:0]     rd_data_d;

    // DEPTH need not be a power of two, so wrap explicitly at the last slot.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_en_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_en_i) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            rd_data_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/axis_to_pull.sv
// ============================================================================
// Module : axis_to_pull
// Brief  : AXI-stream to rate-locked pull converter. Buffers elements, primes
//          to PRIME entries before serving, flags sticky underflow.
// Config : AXIS_TO_PULL_REPRIME_EN - when defined, an underflow returns the
//          block to PRIMING; otherwise it keeps RUNNING.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_to_pull
    import axis_to_pull_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int PRIME       = 2,
    parameter int LEVEL_WIDTH = level_width(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   underflow,
    output logic [LEVEL_WIDTH-1:0] level,
    input  logic [WIDTH-1:0]       idata,
    input  logic                   ivalid,
    output logic                   iready,
    output logic [WIDTH-1:0]       odata,
    output logic                   ovalid,
    input  logic                   oenable
);

    localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL  = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_PRIME = LEVEL_WIDTH'(PRIME);

    state_t                 state_q;
    state_t                 state_d;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic [LEVEL_WIDTH-1:0] level_d;
    logic                   iready_q;
    logic                   iready_d;
    logic                   ovalid_q;
    logic                   ovalid_d;
    logic                   underflow_q;
    logic                   underflow_d;

    logic                   itransfer;
    logic                   pull;
    logic                   empty_pull;

    // Pull decisions use the level at the start of the cycle: an element
    // accepted this cycle is not yet visible to the consumer.
    always_comb begin
        itransfer   = ivalid && iready_q;
        pull        = oenable && (state_q == RUNNING) && (level_q != '0);
        empty_pull  = oenable && (state_q == RUNNING) && (level_q == '0);
        level_d     = LEVEL_WIDTH'(next_level(32'(level_q), pull, itransfer));
        iready_d    = (level_d < LEVEL_FULL);
        ovalid_d    = pull;
        underflow_d = underflow_q || empty_pull;
        state_d     = state_q;
        case (state_q)
            PRIMING: begin
                if (level_d >= LEVEL_PRIME) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
`ifdef AXIS_TO_PULL_REPRIME_EN
                if (empty_pull) begin
                    state_d = PRIMING;
                end
`else
                state_d = RUNNING;
`endif
            end
            default: state_d = PRIMING;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PRIMING;
            level_q     <= '0;
            iready_q    <= 1'b0;
            ovalid_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            iready_q    <= iready_d;
            ovalid_q    <= ovalid_d;
            underflow_q <= underflow_d;
        end
    end

    axis_to_pull_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (itransfer),
        .wr_data_i (idata),
        .rd_en_i   (pull),
        .rd_data_o (odata)
    );

    assign level     = level_q;
    assign iready    = iready_q;
    assign ovalid    = ovalid_q;
    assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_to_pull.sv
// ============================================================================
// Module : tb_axis_to_pull
// Brief  : Directed checks on the default build (DEPTH=4, PRIME=2) followed by
//          a randomised scoreboard run on a DEPTH=3, PRIME=3 instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_to_pull;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a, ivalid_a, iready_a, ovalid_a, oenable_a, underflow_a;
    logic [7:0] idata_a, odata_a;
    logic [2:0] level_a;

    logic       reset_b, ivalid_b, iready_b, ovalid_b, oenable_b, underflow_b;
    logic [7:0] idata_b, odata_b;
    logic [1:0] level_b;

    int checks = 0;
    int errors = 0;

    axis_to_pull #(.WIDTH(8), .DEPTH(4), .PRIME(2)) dut_a (
        .clock     (clock),
        .reset     (reset_a),
        .underflow (underflow_a),
        .level     (level_a),
        .idata     (idata_a),
        .ivalid    (ivalid_a),
        .iready    (iready_a),
        .odata     (odata_a),
        .ovalid    (ovalid_a),
        .oenable   (oenable_a)
    );

    axis_to_pull #(.WIDTH(8), .DEPTH(3), .PRIME(3)) dut_b (
        .clock     (clock),
        .reset     (reset_b),
        .underflow (underflow_b),
        .level     (level_b),
        .idata     (idata_b),
        .ivalid    (ivalid_b),
        .iready    (iready_b),
        .odata     (odata_b),
        .ovalid    (ovalid_b),
        .oenable   (oenable_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input int lvl, input int ir, input int ov,
                            input int od, input int uf);
        check($sformatf("%s.level", tag),     32'(level_a),     32'(lvl));
        check($sformatf("%s.iready", tag),    32'(iready_a),    32'(ir));
        check($sformatf("%s.ovalid", tag),    32'(ovalid_a),    32'(ov));
        check($sformatf("%s.odata", tag),     32'(odata_a),     32'(od));
        check($sformatf("%s.underflow", tag), 32'(underflow_a), 32'(uf));
    endtask

    logic [7:0] q [$];
    bit         m_iready;
    bit         m_run;
    bit         m_uf;
    logic [7:0] m_od;
    int         last_od;

    initial begin
        reset_a = 1'b1; ivalid_a = 1'b0; idata_a = 8'd0; oenable_a = 1'b0;
        reset_b = 1'b1; ivalid_b = 1'b0; idata_b = 8'd0; oenable_b = 1'b0;
        step();
        step();
        expect_a("reset", 0, 0, 0, 0, 0);

        // Priming with oenable held high
        reset_a = 1'b0; ivalid_a = 1'b1; idata_a = 8'd1; oenable_a = 1'b1;
        step(); expect_a("post_reset", 0, 1, 0, 0, 0);
        step(); expect_a("prime1", 1, 1, 0, 0, 0);
        idata_a = 8'd2;
        step(); expect_a("prime2", 2, 1, 0, 0, 0);
        ivalid_a = 1'b0;
        step(); expect_a("first_out", 1, 1, 1, 1, 0);
        step(); expect_a("second_out", 0, 1, 1, 2, 0);
        oenable_a = 1'b0;

        // Fill to full, then one pull reopens iready
        ivalid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idata_a = 8'(10 + i);
            step(); expect_a("fill", i + 1, (i < 3) ? 1 : 0, 0, 2, 0);
        end
        ivalid_a = 1'b0; oenable_a = 1'b1;
        step(); expect_a("pull_full", 3, 1, 1, 10, 0);
        step(); expect_a("pull_more", 2, 1, 1, 11, 0);

        // Simultaneous push and pull at level 2
        ivalid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idata_a = 8'(20 + i);
            step(); expect_a("steady", 2, 1, 1, (i == 0) ? 12 : (i == 1) ? 13 : 18 + i, 0);
        end
        ivalid_a = 1'b0;

        // Drain and underflow
        step(); expect_a("drain1", 1, 1, 1, 28, 0);
        step(); expect_a("drain2", 0, 1, 1, 29, 0);
        step(); expect_a("empty_pull", 0, 1, 0, 29, 1);
`ifdef AXIS_TO_PULL_REPRIME_EN
        ivalid_a = 1'b1; idata_a = 8'd40;
        step(); expect_a("reprime1", 1, 1, 0, 29, 1);
        ivalid_a = 1'b0;
        step(); expect_a("reprime_wait", 1, 1, 0, 29, 1);
        ivalid_a = 1'b1; idata_a = 8'd41;
        step(); expect_a("reprime2", 2, 1, 0, 29, 1);
        ivalid_a = 1'b0;
        step(); expect_a("reprime_out1", 1, 1, 1, 40, 1);
        step(); expect_a("reprime_out2", 0, 1, 1, 41, 1);
        last_od = 41;
`else
        ivalid_a = 1'b1; idata_a = 8'd40;
        step(); expect_a("late_push", 1, 1, 0, 29, 1);
        ivalid_a = 1'b0;
        step(); expect_a("late_served", 0, 1, 1, 40, 1);
        last_od = 40;
`endif
        oenable_a = 1'b0;

        // Reset mid-stream at level 3
        ivalid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idata_a = 8'(50 + i);
            step(); expect_a("refill", i + 1, 1, 0, last_od, 1);
        end
        reset_a = 1'b1; ivalid_a = 1'b0;
        step(); expect_a("mid_reset", 0, 0, 0, 0, 0);
        reset_a = 1'b0; oenable_a = 1'b1;
        step(); expect_a("after_reset", 0, 1, 0, 0, 0);
        ivalid_a = 1'b1; idata_a = 8'd60;
        step(); expect_a("restart1", 1, 1, 0, 0, 0);
        idata_a = 8'd61;
        step(); expect_a("restart2", 2, 1, 0, 0, 0);
        ivalid_a = 1'b0;
        step(); expect_a("restart_out1", 1, 1, 1, 60, 0);
        step(); expect_a("restart_out2", 0, 1, 1, 61, 0);
        oenable_a = 1'b0;
        step(); expect_a("idle", 0, 1, 0, 61, 0);

        // Random traffic against a queue scoreboard on the DEPTH=3, PRIME=3 instance
        reset_b  = 1'b0;
        m_iready = 1'b0;
        m_run    = 1'b0;
        m_uf     = 1'b0;
        m_od     = 8'd0;
        for (int n = 0; n < 3000; n++) begin
            logic       iv, oe, itr, pull, empty;
            logic [7:0] d;
            iv = ($urandom_range(0, 99) < 65);
            oe = ($urandom_range(0, 99) < 55);
            d  = 8'($urandom);
            ivalid_b  = iv;
            oenable_b = oe;
            idata_b   = d;
            itr   = iv && m_iready;
            pull  = oe && m_run && (q.size() > 0);
            empty = oe && m_run && (q.size() == 0);
            step();
            if (pull) m_od = q.pop_front();
            if (itr) q.push_back(d);
            m_iready = (q.size() < 3);
            if (!m_run) begin
                if (q.size() >= 3) m_run = 1'b1;
            end else if (empty) begin
                m_uf = 1'b1;
`ifdef AXIS_TO_PULL_REPRIME_EN
                m_run = 1'b0;
`endif
            end
            check("rnd.ovalid",    32'(ovalid_b),    32'(pull));
            check("rnd.odata",     32'(odata_b),     32'(m_od));
            check("rnd.level",     32'(level_b),     32'(q.size()));
            check("rnd.iready",    32'(iready_b),    32'(m_iready));
            check("rnd.underflow", 32'(underflow_b), 32'(m_uf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
